// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial sequence detector.
// Default pattern/length and the width helper live here so the top and bench agree.
package seq_det_pkg;

    localparam logic [7:0] DEF_PATTERN_C = 8'b0000_1011;
    localparam int         DEF_LEN_C     = 4;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } mode_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Used for the optional match counter of seq_det_prog.
module seq_det_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with registered (Moore) detect flag.
// Define SEQ_DET_CNT_EN to add the saturating match counter (match_cnt/cnt_sat).
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
    parameter int                 DEF_LEN     = DEF_LEN_C,
    parameter int                 CNT_W       = 8,
    localparam int                LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               x,
    output logic               z
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
`endif
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L =
        (DEF_LEN > MAX_LEN) ? MAX_LEN_L : LEN_W'(DEF_LEN);

    if (MAX_LEN < 2 || MAX_LEN > 32 || CNT_W < 1) begin : g_bad_param
        $error("seq_det_prog: illegal MAX_LEN or CNT_W");
    end

    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_nx;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_nx;
    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W:0]     fill_p1;
    mode_e              mode_q;
    logic               accept;
    logic               match;
    logic               z_q;

    always_comb begin
        accept      = in_valid && !cfg_we;
        hist_nx     = {hist_q[MAX_LEN-2:0], x};
        mask        = {MAX_LEN{1'b1}} >> (MAX_LEN_L - len_q);
        fill_p1     = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        len_clamped = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
        // len_q of zero leaves an empty mask, so it must gate explicitly
        match = (len_q != '0)
             && (fill_p1 >= {1'b0, len_q})
             && ((hist_nx & mask) == (pat_q & mask));
        fill_nx = fill_q;
        if (match && (mode_q == NON_OVERLAP)) begin
            fill_nx = '0;
        end else if (fill_q != MAX_LEN_L) begin
            fill_nx = fill_p1[LEN_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= DEF_PATTERN;
            len_q  <= DEF_LEN_L;
            mode_q <= OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else if (cfg_we) begin
            pat_q  <= cfg_pattern;
            len_q  <= len_clamped;
            mode_q <= mode_e'(cfg_overlap);
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else if (accept) begin
            hist_q <= hist_nx;
            fill_q <= fill_nx;
            z_q    <= match;
        end
    end

    assign z = z_q;

`ifdef SEQ_DET_CNT_EN
    seq_det_sat_cnt #(
        .W(CNT_W)
    ) u_sat_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cfg_we),
        .inc  (accept && match),
        .cnt  (match_cnt),
        .sat  (cnt_sat)
    );
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog.
// Counter checks are active when SEQ_DET_CNT_EN is defined.
module tb_seq_det_prog;
    import seq_det_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = len_w(MAX_LEN);
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               x;
    logic               z;
`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_det_prog #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .in_valid   (in_valid),
        .x          (x),
        .z          (z)
`ifdef SEQ_DET_CNT_EN
        ,
        .match_cnt  (match_cnt),
        .cnt_sat    (cnt_sat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [1:0] c,
                             input logic s);
`ifdef SEQ_DET_CNT_EN
        check({tag, "_cnt"}, 32'(match_cnt), 32'(c));
        check({tag, "_sat"}, 32'(cnt_sat), 32'(s));
`else
        if (c === 2'bxx && s === 1'bx) $display("%s", tag);
`endif
    endtask

    task automatic send(input logic b, input logic ez, input string tag);
        in_valid = 1'b1;
        x        = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = 1'b0;
        check(tag, 32'(z), 32'(ez));
    endtask

    task automatic send_stream(input logic [7:0] bits, input int n,
                               input logic [7:0] ez, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], ez[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    task automatic idle(input int n, input logic ez, input string tag);
        repeat (n) @(posedge clk);
        #1;
        check(tag, 32'(z), 32'(ez));
    endtask

    // The 1 presented with cfg_we must be ignored by the detector.
    task automatic cfg(input logic [7:0] pat, input logic [LEN_W-1:0] len,
                       input logic ov);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_we      = 1'b1;
        in_valid    = 1'b1;
        x           = 1'b1;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        x        = 1'b0;
        check("cfg_z", 32'(z), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        x           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_z", 32'(z), 32'd0);
        check_cnt("rst", 2'd0, 1'b0);
        rst_n = 1'b1;

        send_stream(8'b0101_1011, 7, 8'b0000_1001, "ovl");
        check_cnt("ovl", 2'd2, 1'b0);

        cfg(8'b0000_1011, 4'd4, 1'b0);
        check_cnt("cfg_clr", 2'd0, 1'b0);
        send_stream(8'b0101_1011, 7, 8'b0000_1000, "novl");
        check_cnt("novl", 2'd1, 1'b0);

        cfg(8'b1100_1010, 4'd8, 1'b1);
        send(1'b1, 1'b0, "len8_b1");
        send(1'b1, 1'b0, "len8_b2");
        idle(2, 1'b0, "len8_gap1");
        send(1'b0, 1'b0, "len8_b3");
        send(1'b0, 1'b0, "len8_b4");
        send(1'b1, 1'b0, "len8_b5");
        idle(1, 1'b0, "len8_gap2");
        send(1'b0, 1'b0, "len8_b6");
        send(1'b1, 1'b0, "len8_b7");
        send(1'b0, 1'b1, "len8_b8");
        idle(3, 1'b1, "len8_hold");
        check_cnt("len8", 2'd1, 1'b0);

        cfg(8'b0000_0001, 4'd1, 1'b1);
        send_stream(8'b0000_1101, 4, 8'b0000_1101, "len1");
        check_cnt("len1", 2'd3, 1'b1);

        cfg(8'b0000_1011, 4'd4, 1'b1);
        send_stream(8'b0000_0101, 3, 8'b0000_0000, "pre");
        cfg(8'b0000_1011, 4'd4, 1'b1);
        send(1'b1, 1'b0, "cfgmid_tail");
        check_cnt("cfgmid", 2'd0, 1'b0);

        cfg(8'b0000_0001, 4'd1, 1'b0);
        send_stream(8'b0001_1111, 5, 8'b0001_1111, "sat");
        check_cnt("sat", 2'd3, 1'b1);

        cfg(8'b0000_0011, 4'd0, 1'b1);
        send_stream(8'b0000_1011, 4, 8'b0000_0000, "len0");

        cfg(8'b1100_1010, 4'd15, 1'b1);
        send_stream(8'b1100_1010, 8, 8'b0000_0001, "clamp");

        cfg(8'b0000_0001, 4'd1, 1'b1);
        send(1'b1, 1'b1, "prerst");
        cfg(8'b0000_1011, 4'd4, 1'b0);
        send_stream(8'b0000_0101, 3, 8'b0000_0000, "midrst");
        rst_n = 1'b0;
        #2;
        check("rst_async_z", 32'(z), 32'd0);
        check_cnt("rst_async", 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1'b1, 1'b0, "post_rst_b1");
        send_stream(8'b0000_0011, 3, 8'b0000_0001, "post_rst");
        check_cnt("post_rst", 2'd1, 1'b0);
        send_stream(8'b0000_1011, 3, 8'b0000_0001, "post_rst_ovl");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
SEQ_DET_PROG -- requirements
Module: seq_det_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 SHALL have parameter DEF_PATTERN, default 8'b0000_1011, giving the reset-time pattern.
REQ-003 SHALL have parameter DEF_LEN, default 4, giving the reset-time pattern length.
REQ-004 SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-005 SHALL have ports, one per line as follows:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  in  LEN_W = $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  x is sampled only when this is high.
- x  in  1  serial data bit.
- z  out  1  Moore detect flag.
- match_cnt  out  CNT_W  number of matches (present only with SEQ_DET_CNT_EN).
- cnt_sat  out  1  match counter saturated (present only with SEQ_DET_CNT_EN).

Function
REQ-006 SHALL hold the active configuration (pattern, len, overlap) in registers loaded on a clk edge when cfg_we=1.
REQ-007 SHALL shift x into a MAX_LEN-bit history register on each edge with in_valid=1 and cfg_we=0, and SHALL increment a fill counter that saturates at MAX_LEN.
REQ-008 SHALL declare a match on a sample when fill+1 >= len and the new history[len-1:0] == pattern[len-1:0].
REQ-009 SHALL register z: z=1 from the cycle after the completing sample until the next accepted sample, which re-evaluates z; in_valid=0 cycles hold z.
REQ-010 SHALL, in overlap mode, keep the history and fill after a match, so that 1011011 with pattern 1011 asserts z twice.
REQ-011 SHALL, in non-overlap mode, clear fill to 0 on the matching sample, so that 1011011 asserts z once.
REQ-012 SHALL treat a cfg_len of 0 as detection disabled (z held at 0), and SHALL clamp a cfg_len > MAX_LEN to MAX_LEN.
REQ-013 SHALL, on cfg_we=1, clear the history, fill and z on that edge, and SHALL ignore the x sampled in that cycle.
REQ-014 SHALL, when SEQ_DET_CNT_EN is defined, increment match_cnt on each match, saturate at 2^CNT_W-1, and hold cnt_sat=1 once saturated.
REQ-015 SHALL clear match_cnt and cnt_sat on cfg_we=1.
REQ-016 SHALL compute z solely from registered state, with no combinational path from x to z.

Reset
REQ-017 SHALL, while rst_n=0, force z=0, history=0, fill=0, match_cnt=0 and cnt_sat=0.
REQ-018 SHALL, while rst_n=0, force pattern=DEF_PATTERN, len=DEF_LEN and overlap=1.
REQ-019 SHALL restart detection from an empty history after reset deasserts mid-stream; bits received before reset SHALL never contribute to a match.

Configuration
REQ-020 SHALL use macro SEQ_DET_CNT_EN.
- Defined: match_cnt and cnt_sat exist and behave per REQ-014 and REQ-015.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Structure
REQ-021 SHALL place in package seq_det_pkg:
- the LEN_W width function;
- the default pattern and length constants;
- the mode typedef (OVERLAP / NON_OVERLAP).
REQ-022 SHALL implement the counter as sub-module seq_det_sat_cnt (CNT_W-wide saturating counter with sync clear), instantiated only under SEQ_DET_CNT_EN.

Verification
REQ-023 The bench SHALL cover: reset defaults, stream 1,0,1,1,0,1,1 -> z high after sample 4 and after sample 7; match_cnt=2.
REQ-024 The bench SHALL cover: cfg_overlap=0, same stream -> z high only after sample 4; match_cnt=1.
REQ-025 The bench SHALL cover: pattern 8'b1100_1010, len=8, stream with in_valid gaps -> z high once after the 8th valid bit, held through idle cycles.
REQ-026 The bench SHALL cover: len=1, pattern bit 1, stream 1,1,0,1 -> z=1,1,0,1, each lagging its sample by one cycle.
REQ-027 The bench SHALL cover: cfg_we after 1,0,1 and then a trailing 1 -> no match; z=0; match_cnt=0.
REQ-028 The bench SHALL cover: CNT_W=2 with 5 matches -> match_cnt=3 and cnt_sat=1; rst_n pulse mid-pattern -> all outputs 0 and no false match.
